reg_shift_out: RTL and testbench

REG_SHIFT_OUT -- requirements
Module: reg_shift_out

---
 rtl/reg_shift_out.sv | 144 ++++++++++++++
 tb/tb_reg_shift_out.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_shift_out.sv
// Serializes a parallel word MSB-first onto an external shift-register chain,
// then strobes the chain's storage latch. All outputs come straight from flops.
module reg_shift_out #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] D,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = $clog2(CLK_DIV + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BIT_ZERO = BCW'(0);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
  localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);
  localparam logic [DCW-1:0] DIV_ZERO = DCW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [DCW-1:0]   divcnt_q, divcnt_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_last_s;

  assign div_last_s = (divcnt_q == DIV_LAST);

  // Next-state, datapath and output decode. Outputs are decoded from the
  // current state and registered, so they trail the state by one cycle.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d  = D;
          bitcnt_d = BIT_LAST;
          divcnt_d = DIV_ZERO;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        if (div_last_s) begin
          divcnt_d = DIV_ZERO;
          state_d  = HOLD;
        end else begin
          divcnt_d = divcnt_q + DIV_ONE;
        end
      end
      HOLD: begin
        if (div_last_s) begin
          divcnt_d = DIV_ZERO;
          if (bitcnt_q == BIT_ZERO) begin
            state_d = LATCH;
          end else begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q - BIT_ONE;
            state_d  = SETUP;
          end
        end else begin
          divcnt_d = divcnt_q + DIV_ONE;
        end
      end
      LATCH: begin
        if (div_last_s) begin
          divcnt_d = DIV_ZERO;
          state_d  = IDLE;
        end else begin
          divcnt_d = divcnt_q + DIV_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        divcnt_d = DIV_ZERO;
      end
    endcase

    sclk_d  = (state_q == HOLD);
    latch_d = (state_q == LATCH);
    busy_d  = (state_q != IDLE);
    // latch_q is the lagged LATCH indication, so this fires once on the way out
    done_d  = (state_q == IDLE) && latch_q;
    if (state_q == SETUP) begin
      sdata_d = shreg_q[WIDTH-1];
    end else begin
      sdata_d = sdata_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk  = sclk_q;
  assign sdata = sdata_q;
  assign latch = latch_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_reg_shift_out.sv
// Scoreboarded random/directed bench for reg_shift_out (CLK_DIV=2 main DUT,
// CLK_DIV=1 second instance for the fast-clock stream case).
module tb_reg_shift_out;
  localparam int W    = 32;
  localparam int C    = 2;
  localparam int TLEN = 2*W*C + C + 1;   // accept edge to done edge
  localparam int NONE = -1000000;

  logic clk = 1'b0;
  logic rst, start, start1;
  logic [W-1:0] d, d1;
  logic sclk, sdata, latch, busy, done;
  logic sclk1, sdata1, latch1, busy1, done1;

  int vectors = 0, errors = 0;
  int edge_n = 0, next_ok = 0, prev_a = NONE, cur_a = NONE;
  logic [W-1:0] exp_q[$];

  reg_shift_out #(.WIDTH(W), .CLK_DIV(C)) u_dut (
    .clk(clk), .rst(rst), .start(start), .D(d),
    .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy), .done(done));

  reg_shift_out #(.WIDTH(W), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .D(d1),
    .sclk(sclk1), .sdata(sdata1), .latch(latch1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Expected {busy,sclk,latch,done} in the cycle after edge e for a transfer accepted at edge a.
  function automatic logic [3:0] model_outs(input int a, input int e);
    int r;
    logic [3:0] o;
    r = e - a;
    o = 4'b0000;
    if (r >= 1 && r <= 2*W*C + C) o[3] = 1'b1;
    if (r >= 1 && r <= 2*W*C)     o[2] = (((r - 1) / C) % 2) == 1;
    if (r > 2*W*C && r <= 2*W*C + C) o[1] = 1'b1;
    if (r == TLEN)                o[0] = 1'b1;
    return o;
  endfunction

  // Drive one cycle of stimulus for the upcoming edge and update the reference model.
  task automatic step(input logic st, input logic [W-1:0] dv);
    @(posedge clk); #1;
    start = st;
    d     = dv;
    if (st && !rst && edge_n >= next_ok) begin
      exp_q.push_back(dv);
      prev_a  = cur_a;
      cur_a   = edge_n;
      next_ok = edge_n + TLEN;
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while ((exp_q.size() > 0 || edge_n < next_ok + 2) && b > 0) begin
      step(1'b0, $urandom);
      b--;
    end
    check("drain_timeout_pending", exp_q.size(), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    prev_a  = NONE;
    cur_a   = NONE;
    next_ok = 0;
  endtask

  // Monitor: per-cycle output timing plus serial stream reassembly on each done.
  logic [W-1:0] word;
  int nbits;
  logic sclk_p;
  logic [3:0] exp_o;
  always @(negedge clk) begin
    if (rst) begin
      word   = '0;
      nbits  = 0;
      sclk_p = 1'b0;
      check("outs_in_reset", {busy, sclk, latch, done, sdata}, 5'b0);
    end else begin
      exp_o = model_outs(prev_a, edge_n - 1) | model_outs(cur_a, edge_n - 1);
      check("busy_sclk_latch_done", {busy, sclk, latch, done}, exp_o);
      if (sclk && !sclk_p) begin
        word = {word[W-2:0], sdata};
        nbits++;
      end
      sclk_p = sclk;
      if (done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL done_without_transfer: got done=1 required no pending transfer");
        end else begin
          check("stream", word, exp_q.pop_front());
          check("bit_count", nbits, W);
        end
        word  = '0;
        nbits = 0;
      end
    end
  end

  int a1, last_rise, n1;
  logic [W-1:0] w1;
  logic p1, seen1;

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; d = '0; d1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_u1", {busy1, sclk1, latch1, done1, sdata1}, 5'b0);
    rst = 1'b0;

    // CLK_DIV=1 instance: stream reassembly, sclk period and done latency.
    @(posedge clk); #1;
    start1 = 1'b1; d1 = 32'hA5A5_F00F; a1 = edge_n;
    @(posedge clk); #1;
    start1 = 1'b0; d1 = '0;
    w1 = '0; n1 = 0; p1 = 1'b0; seen1 = 1'b0; last_rise = 0;
    for (int i = 0; i < 200 && !seen1; i++) begin
      @(negedge clk);
      if (sclk1 && !p1) begin
        if (n1 == 0) check("u1_first_rise", edge_n - 1, a1 + 2);
        else         check("u1_sclk_period", (edge_n - 1) - last_rise, 2);
        last_rise = edge_n - 1;
        w1 = {w1[W-2:0], sdata1};
        n1++;
      end
      p1 = sclk1;
      if (done1) begin
        check("u1_done_edge", edge_n - 1, a1 + 66);
        seen1 = 1'b1;
      end
    end
    check("u1_done_seen", seen1, 1'b1);
    check("u1_stream", w1, 32'hA5A5_F00F);
    check("u1_bits", n1, W);

    // Single-bit-ends pattern, then idle with D wiggling.
    step(1'b1, 32'h8000_0001);
    drain(400);

    // Restart attempt at sclk rise 10 of an all-zero transfer is ignored.
    step(1'b1, 32'h0000_0000);
    while (edge_n < cur_a + 19*C + 1) step(1'b0, $urandom);
    step(1'b1, 32'hFFFF_FFFF);
    step(1'b0, 32'hFFFF_FFFF);
    drain(400);

    // start held high: back-to-back transfers, fresh D each time.
    for (int i = 0; i < 3*TLEN + 2; i++) step(1'b1, $urandom);
    step(1'b0, $urandom);
    drain(400);

    // Asynchronous reset during HOLD of the 16th bit, then a full clean transfer.
    step(1'b1, $urandom);
    while (edge_n < cur_a + 31*C + 1) step(1'b0, $urandom);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset_outs", {busy, sclk, latch, done, sdata}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, $urandom);
    drain(400);

    // Random start pulses and data.
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 7) == 0, $urandom);
    step(1'b0, $urandom);
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
